// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one word read at a time, presents the
// returned instruction to the IF/ID register, and buffers it while that register is stalled.
module fetch_unit #(
    parameter int                 WIDTH    = 32,
    parameter logic [WIDTH-1:0]   RESET_PC = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_read,
    output logic [WIDTH-1:0] imem_address,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             imem_resp,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_instr,
    output logic             if_valid,
    output logic             ifid_load,
    output logic             ifid_flush
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [WIDTH-1:0] WORD_MASK = ~{{(WIDTH-2){1'b0}}, 2'b11};
    localparam logic [WIDTH-1:0] PC_STEP   = {{(WIDTH-3){1'b0}}, 3'b100};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [WIDTH-1:0] hold_instr_q, hold_instr_d;

    logic             read_s;
    logic [WIDTH-1:0] addr_s;
    logic             valid_s;
    logic [WIDTH-1:0] ipc_s;
    logic [WIDTH-1:0] instr_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic [WIDTH-1:0] redir_pc_s;

    assign pc_inc_s   = pc_q + PC_STEP;
    assign redir_pc_s = redirect_pc & WORD_MASK;

    // Next-state and presentation logic; redirect outranks stall and imem_resp everywhere.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        read_s       = 1'b0;
        addr_s       = pc_q;
        valid_s      = 1'b0;
        ipc_s        = pc_q;
        instr_s      = {WIDTH{1'b0}};
        case (state_q)
            ST_FETCH: begin
                read_s  = 1'b1;
                valid_s = imem_resp;
                instr_s = imem_rdata;
                if (redirect) begin
                    pc_d = redir_pc_s;
                    if (imem_resp) begin
                        state_d = ST_FETCH;
                    end else begin
                        // The read already on the bus must still complete before refetching.
                        pend_d  = pc_q;
                        state_d = ST_DISCARD;
                    end
                end else if (imem_resp) begin
                    if (!stall) begin
                        pc_d = pc_inc_s;
                    end else begin
                        hold_pc_d    = pc_q;
                        hold_instr_d = imem_rdata;
                        state_d      = ST_HOLD;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_HOLD: begin
                valid_s = 1'b1;
                ipc_s   = hold_pc_q;
                instr_s = hold_instr_q;
                if (redirect) begin
                    pc_d         = redir_pc_s;
                    hold_pc_d    = {WIDTH{1'b0}};
                    hold_instr_d = {WIDTH{1'b0}};
                    state_d      = ST_FETCH;
                end else if (!stall) begin
                    pc_d    = pc_inc_s;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_DISCARD: begin
                read_s = 1'b1;
                addr_s = pend_q;
                if (redirect) begin
                    pc_d = redir_pc_s;
                end else if (imem_resp) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            default: begin
                state_d = ST_FETCH;
                pc_d    = RESET_PC;
            end
        endcase
    end

    assign imem_read    = rst_n & read_s;
    assign imem_address = addr_s & WORD_MASK;
    assign if_valid     = rst_n & valid_s;
    assign if_pc        = ipc_s;
    assign if_instr     = instr_s;
    assign ifid_load    = rst_n & valid_s & ~stall & ~redirect;
    assign ifid_flush   = ~rst_n | redirect;

    // State, PC, pending-address and hold-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= {WIDTH{1'b0}};
            hold_pc_q    <= {WIDTH{1'b0}};
            hold_instr_q <= {WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
        end
    end

endmodule
